// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester-side request/response bundle for the shared ALU arbiter.
//   req_valid/req_ready  per-requester request handshake (NREQ bits)
//   req_a/req_b          packed operands, requester i at [i*P +: P]
//   req_op               packed op codes, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready  per-requester response handshake (NREQ bits)
//   rsp_result/rsp_flags shared captured Result and ALUFlags
interface alu_share_arbiter_if #(parameter int P = 32, parameter int NREQ = 2);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*P-1:0] req_a;
    logic [NREQ*P-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [P-1:0]      rsp_result;
    logic [3:0]        rsp_flags;
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between NREQ requesters.
//   clk, rst        clock and synchronous active-high reset
//   bus (slave)     requester handshakes, operands, shared response bus
//   alu_a/b/op      registered operands driven to the ALU
//   alu_result/flags ALU outputs, captured after ALU_CYCLES cycles
//   busy            high whenever an operation is in flight or awaiting its response
module alu_share_arbiter #(
    parameter int P          = 32,
    parameter int NREQ       = 2,
    parameter int ALU_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_arbiter_if.slave bus,
    output logic [P-1:0]    alu_a,
    output logic [P-1:0]    alu_b,
    output logic [2:0]      alu_op,
    input  logic [P-1:0]    alu_result,
    input  logic [3:0]      alu_flags,
    output logic            busy
);
    localparam int W = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t         state;
    logic [W-1:0]   rr_ptr;
    logic [W-1:0]   owner;
    logic [W-1:0]   gnt;
    logic           found;
    logic [3:0]     cnt;
    logic [P-1:0]   result;
    logic [3:0]     flags;
    // search starts at rr_ptr and wraps, so the requester after the last winner has priority
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                gnt   = W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end
    assign bus.req_ready  = ((state == IDLE) && found) ? (NREQ'(1) << gnt) : '0;
    assign bus.rsp_valid  = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign bus.rsp_result = result;
    assign bus.rsp_flags  = flags;
    assign busy           = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    alu_a  <= bus.req_a[gnt*P +: P];
                    alu_b  <= bus.req_b[gnt*P +: P];
                    alu_op <= bus.req_op[gnt*3 +: 3];
                    owner  <= gnt;
                    rr_ptr <= W'((int'(gnt) + 1) % NREQ);
                    cnt    <= '0;
                    state  <= EXEC;
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(ALU_CYCLES - 1)) begin
                        result <= alu_result;
                        flags  <= alu_flags;
                        state  <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready[owner]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of three arbiter configurations against an adder ALU stub.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.P(32), .NREQ(2)) i0 ();
    alu_share_arbiter_if #(.P(32), .NREQ(2)) i1 ();
    alu_share_arbiter_if #(.P(32), .NREQ(4)) i2 ();
    logic [31:0] a0, b0, r0, a1, b1, r1, a2, b2, r2;
    logic [2:0]  op0, op1, op2;
    logic [3:0]  f0, f1, f2;
    logic        busy0, busy1, busy2;

    assign r0 = a0 + b0 + {29'd0, op0};
    assign f0 = {1'b0, op0};
    assign r1 = a1 + b1 + {29'd0, op1};
    assign f1 = {1'b0, op1};
    assign r2 = a2 + b2 + {29'd0, op2};
    assign f2 = {1'b0, op2};

    alu_share_arbiter #(.P(32), .NREQ(2), .ALU_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .bus(i0), .alu_a(a0), .alu_b(b0), .alu_op(op0),
        .alu_result(r0), .alu_flags(f0), .busy(busy0));
    alu_share_arbiter #(.P(32), .NREQ(2), .ALU_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .bus(i1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_result(r1), .alu_flags(f1), .busy(busy1));
    alu_share_arbiter #(.P(32), .NREQ(4), .ALU_CYCLES(1)) u2 (
        .clk(clk), .rst(rst), .bus(i2), .alu_a(a2), .alu_b(b2), .alu_op(op2),
        .alu_result(r2), .alu_flags(f2), .busy(busy2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        i0.req_valid = '0; i0.req_a = '0; i0.req_b = '0; i0.req_op = '0; i0.rsp_ready = '0;
        i1.req_valid = '0; i1.req_a = '0; i1.req_b = '0; i1.req_op = '0; i1.rsp_ready = '0;
        i2.req_valid = '0; i2.req_a = '0; i2.req_b = '0; i2.req_op = '0; i2.rsp_ready = '0;
        tick();
        tick();
        check("rst_busy", busy0, 0);
        check("rst_rsp_valid", i0.rsp_valid, 0);
        check("rst_result", i0.rsp_result, 0);
        check("rst_flags", i0.rsp_flags, 0);
        check("rst_alu_a", a0, 0);
        check("rst_alu_op", op0, 0);
        rst = 1'b0;
        #1;
        check("rst_req_ready", i0.req_ready, 0);

        // single op, latency 2 with ALU_CYCLES=1
        i0.req_a = {32'd0, 32'd5};
        i0.req_b = {32'd0, 32'd3};
        i0.req_op = {3'd0, 3'd1};
        i0.req_valid = 2'b01;
        #1;
        check("t1_ready", i0.req_ready, 2'b01);
        tick();
        i0.req_valid = 2'b00;
        check("t1_exec_busy", busy0, 1);
        check("t1_exec_alu_a", a0, 5);
        check("t1_exec_rsp", i0.rsp_valid, 0);
        check("t1_exec_ready", i0.req_ready, 0);
        tick();
        check("t1_rsp_valid", i0.rsp_valid, 2'b01);
        check("t1_result", i0.rsp_result, 9);
        check("t1_flags", i0.rsp_flags, 4'b0001);
        i0.rsp_ready = 2'b01;
        tick();
        check("t1_done_rsp", i0.rsp_valid, 0);
        check("t1_done_busy", busy0, 0);
        check("t1_alu_a_kept", a0, 5);
        i0.rsp_ready = 2'b00;

        // alternating grants from rr_ptr=0, one response every 3 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i0.req_a = {32'd100, 32'd10};
        i0.req_b = {32'd1, 32'd20};
        i0.req_op = {3'd3, 3'd2};
        i0.rsp_ready = 2'b11;
        i0.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc = 99;
            for (int n = 1; n <= 10; n++) begin
                tick();
                if (i0.rsp_valid != 0) begin
                    cyc = n;
                    break;
                end
            end
            check($sformatf("t2_gap%0d", k), cyc, (k == 0) ? 2 : 3);
            check($sformatf("t2_owner%0d", k), i0.rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t2_result%0d", k), i0.rsp_result, (k % 2 == 0) ? 32 : 104);
            check($sformatf("t2_flags%0d", k), i0.rsp_flags, (k % 2 == 0) ? 2 : 3);
        end
        i0.req_valid = 2'b00;
        tick();
        check("t2_idle", busy0, 0);
        i0.rsp_ready = 2'b00;

        // owner holds response; other requester waits; non-owner rsp_ready ignored
        i0.req_a = {32'd100, 32'd7};
        i0.req_b = {32'd1, 32'd8};
        i0.req_op = {3'd3, 3'd0};
        i0.req_valid = 2'b11;
        #1;
        check("t3_ready", i0.req_ready, 2'b01);
        tick();
        i0.req_valid = 2'b10;
        tick();
        i0.rsp_ready = 2'b10;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("t3_hold_valid%0d", n), i0.rsp_valid, 2'b01);
            check($sformatf("t3_hold_result%0d", n), i0.rsp_result, 15);
            check($sformatf("t3_hold_ready%0d", n), i0.req_ready, 0);
            tick();
        end
        i0.rsp_ready = 2'b01;
        #1;
        check("t3_hs_ready", i0.req_ready, 0);
        tick();
        check("t3_after_rsp", i0.rsp_valid, 0);
        check("t3_after_ready", i0.req_ready, 2'b10);
        i0.rsp_ready = 2'b00;
        tick();
        i0.req_valid = 2'b00;
        tick();
        check("t3_r1_valid", i0.rsp_valid, 2'b10);
        check("t3_r1_result", i0.rsp_result, 104);
        i0.rsp_ready = 2'b11;
        tick();
        check("t3_r1_idle", busy0, 0);
        i0.rsp_ready = 2'b00;

        // ALU_CYCLES=3, wrap-around add
        i1.req_a = {32'hFFFF_FFFF, 32'd0};
        i1.req_b = {32'd1, 32'd0};
        i1.req_op = {3'd0, 3'd0};
        i1.req_valid = 2'b10;
        #1;
        check("t4_ready", i1.req_ready, 2'b10);
        cyc = 99;
        for (int n = 1; n <= 10; n++) begin
            tick();
            i1.req_valid = 2'b00;
            if (n == 2) check("t4_exec_hold", a1, 32'hFFFF_FFFF);
            if (i1.rsp_valid != 0) begin
                cyc = n;
                break;
            end
        end
        check("t4_latency", cyc, 4);
        check("t4_valid", i1.rsp_valid, 2'b10);
        check("t4_result", i1.rsp_result, 0);
        check("t4_flags", i1.rsp_flags, 0);
        i1.rsp_ready = 2'b10;
        tick();
        check("t4_idle", busy1, 0);
        check("t4_rsp_clear", i1.rsp_valid, 0);
        i1.rsp_ready = 2'b00;

        // reset mid-EXEC discards the op; round-robin pointer restarts at 0
        i0.req_a = {32'd0, 32'd9};
        i0.req_b = {32'd0, 32'd9};
        i0.req_op = {3'd0, 3'd1};
        i0.req_valid = 2'b01;
        tick();
        i0.req_valid = 2'b00;
        rst = 1'b1;
        #1;
        check("t5_exec_busy", busy0, 1);
        tick();
        rst = 1'b0;
        check("t5_rst_busy", busy0, 0);
        check("t5_rst_rsp", i0.rsp_valid, 0);
        check("t5_rst_alu_a", a0, 0);
        tick();
        check("t5_no_rsp", i0.rsp_valid, 0);
        i0.req_valid = 2'b11;
        #1;
        check("t5_rr0", i0.req_ready, 2'b01);
        tick();
        i0.req_valid = 2'b00;
        tick();
        check("t5_valid", i0.rsp_valid, 2'b01);
        check("t5_result", i0.rsp_result, 19);
        i0.rsp_ready = 2'b01;
        tick();
        check("t5_idle", busy0, 0);
        i0.rsp_ready = 2'b00;

        // NREQ=4: move rr_ptr to 2, then requesters 1 and 3 -> 3 first, then 1
        i2.req_a = {32'd3, 32'd0, 32'd1, 32'd0};
        i2.req_b = {32'd3, 32'd0, 32'd1, 32'd0};
        i2.req_op = '0;
        i2.rsp_ready = 4'b1111;
        i2.req_valid = 4'b0010;
        #1;
        check("t6_first", i2.req_ready, 4'b0010);
        tick();
        i2.req_valid = 4'b0000;
        tick();
        check("t6_first_rsp", i2.rsp_valid, 4'b0010);
        check("t6_first_res", i2.rsp_result, 2);
        tick();
        i2.req_valid = 4'b1010;
        #1;
        check("t6_grant3", i2.req_ready, 4'b1000);
        cyc = 99;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (i2.rsp_valid != 0) begin
                cyc = n;
                break;
            end
        end
        check("t6_lat3", cyc, 2);
        check("t6_rsp3", i2.rsp_valid, 4'b1000);
        check("t6_res3", i2.rsp_result, 6);
        tick();
        check("t6_grant1", i2.req_ready, 4'b0010);
        tick();
        i2.req_valid = 4'b0000;
        tick();
        check("t6_rsp1", i2.rsp_valid, 4'b0010);
        check("t6_res1", i2.rsp_result, 2);
        tick();
        check("t6_idle", busy2, 0);
        i2.rsp_ready = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
